// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, flag bit positions, branch condition
// encodings and the writeback buffer occupancy type.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;

  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_VS = 4'd4;
  localparam logic [3:0] COND_VC = 4'd5;
  localparam logic [3:0] COND_HI = 4'd6;
  localparam logic [3:0] COND_LS = 4'd7;
  localparam logic [3:0] COND_AL = 4'd8;
  localparam logic [3:0] COND_NV = 4'd9;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch condition evaluator: maps committed {z,c,v} flags and a
// condition select to a single taken/not-taken bit.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [3:0] cond_sel,
  output logic       cond_true
);

  logic z_s;
  logic c_s;
  logic v_s;

  assign z_s = flags[FLG_Z];
  assign c_s = flags[FLG_C];
  assign v_s = flags[FLG_V];

  // Condition decode; every unlisted encoding is "never".
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      COND_EQ: cond_true = z_s;
      COND_NE: cond_true = !z_s;
      COND_CS: cond_true = c_s;
      COND_CC: cond_true = !c_s;
      COND_VS: cond_true = v_s;
      COND_VC: cond_true = !v_s;
      COND_HI: cond_true = c_s && !z_s;
      COND_LS: cond_true = !c_s || z_s;
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry head/skid FIFO, committed status flags and branch
// condition output. Build macro ALU_WB_STICKY_V_EN adds sticky_v / sticky_clr.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res,
  input  logic              in_z,
  input  logic              in_c,
  input  logic              in_v,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_fwe,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [2:0]        flags_q,
  input  logic [3:0]        cond_sel,
  output logic              cond_true
`ifdef ALU_WB_STICKY_V_EN
  ,
  output logic              sticky_v,
  input  logic              sticky_clr
`endif
);

  occ_e              occ_q;
  occ_e              occ_d;
  logic              in_ready_q;
  logic              in_ready_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic              out_wen_q;
  logic              out_wen_d;
  logic [2:0]        flags_d;

  logic [DATA_W-1:0] head_res_q;
  logic [DATA_W-1:0] head_res_d;
  logic [RD_W-1:0]   head_rd_q;
  logic [RD_W-1:0]   head_rd_d;
  logic              head_wen_q;
  logic              head_wen_d;
  logic              head_fwe_q;
  logic              head_fwe_d;
  logic [2:0]        head_flg_q;
  logic [2:0]        head_flg_d;

  logic [DATA_W-1:0] skid_res_q;
  logic [DATA_W-1:0] skid_res_d;
  logic [RD_W-1:0]   skid_rd_q;
  logic [RD_W-1:0]   skid_rd_d;
  logic              skid_wen_q;
  logic              skid_wen_d;
  logic              skid_fwe_q;
  logic              skid_fwe_d;
  logic [2:0]        skid_flg_q;
  logic [2:0]        skid_flg_d;

  logic [2:0]        in_flg_s;
  logic              accept_s;
  logic              commit_s;

  assign in_flg_s = {in_z, in_c, in_v};
  assign accept_s = in_valid && in_ready_q;
  assign commit_s = out_valid_q && out_ready;

  // Occupancy FSM and head/skid data movement; order is always head before skid.
  always_comb begin
    occ_d      = occ_q;
    head_res_d = head_res_q;
    head_rd_d  = head_rd_q;
    head_wen_d = head_wen_q;
    head_fwe_d = head_fwe_q;
    head_flg_d = head_flg_q;
    skid_res_d = skid_res_q;
    skid_rd_d  = skid_rd_q;
    skid_wen_d = skid_wen_q;
    skid_fwe_d = skid_fwe_q;
    skid_flg_d = skid_flg_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept_s) begin
          head_res_d = in_res;
          head_rd_d  = in_rd;
          head_wen_d = in_wen;
          head_fwe_d = in_fwe;
          head_flg_d = in_flg_s;
          occ_d      = OCC_ONE;
        end else begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (accept_s && commit_s) begin
          // Pass-through: the new entry replaces the departing head directly.
          head_res_d = in_res;
          head_rd_d  = in_rd;
          head_wen_d = in_wen;
          head_fwe_d = in_fwe;
          head_flg_d = in_flg_s;
          occ_d      = OCC_ONE;
        end else if (accept_s) begin
          skid_res_d = in_res;
          skid_rd_d  = in_rd;
          skid_wen_d = in_wen;
          skid_fwe_d = in_fwe;
          skid_flg_d = in_flg_s;
          occ_d      = OCC_FULL;
        end else if (commit_s) begin
          occ_d = OCC_EMPTY;
        end else begin
          occ_d = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (commit_s) begin
          head_res_d = skid_res_q;
          head_rd_d  = skid_rd_q;
          head_wen_d = skid_wen_q;
          head_fwe_d = skid_fwe_q;
          head_flg_d = skid_flg_q;
          occ_d      = OCC_ONE;
        end else begin
          occ_d = OCC_FULL;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // Registered handshake/output qualifiers and flag commit.
  always_comb begin
    out_valid_d = (occ_d != OCC_EMPTY);
    out_wen_d   = out_valid_d && head_wen_d;
    in_ready_d  = (int'(occ_d) < DEPTH);
    if (commit_s && head_fwe_q) begin
      flags_d = head_flg_q;
    end else begin
      flags_d = flags_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_wen_q   <= 1'b0;
      flags_q     <= 3'b000;
      head_res_q  <= '0;
      head_rd_q   <= '0;
      head_wen_q  <= 1'b0;
      head_fwe_q  <= 1'b0;
      head_flg_q  <= 3'b000;
      skid_res_q  <= '0;
      skid_rd_q   <= '0;
      skid_wen_q  <= 1'b0;
      skid_fwe_q  <= 1'b0;
      skid_flg_q  <= 3'b000;
    end else begin
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_wen_q   <= out_wen_d;
      flags_q     <= flags_d;
      head_res_q  <= head_res_d;
      head_rd_q   <= head_rd_d;
      head_wen_q  <= head_wen_d;
      head_fwe_q  <= head_fwe_d;
      head_flg_q  <= head_flg_d;
      skid_res_q  <= skid_res_d;
      skid_rd_q   <= skid_rd_d;
      skid_wen_q  <= skid_wen_d;
      skid_fwe_q  <= skid_fwe_d;
      skid_flg_q  <= skid_flg_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = head_res_q;
  assign out_rd    = head_rd_q;
  assign out_wen   = out_wen_q;

  alu_cond_eval u_cond_eval (
    .flags     (flags_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

`ifdef ALU_WB_STICKY_V_EN
  logic sticky_q;
  logic sticky_d;

  // Sticky overflow: a committing overflow beats a coincident clear.
  always_comb begin
    if (commit_s && head_fwe_q && head_flg_q[FLG_V]) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_v = sticky_q;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios plus a randomized run
// checked against a queue-based model of the stage.
module tb_alu_wb_stage;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        fwe;
    logic [2:0]  flg;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_res = 32'd0;
  logic        in_z = 1'b0;
  logic        in_c = 1'b0;
  logic        in_v = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_wen = 1'b0;
  logic        in_fwe = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [2:0]  flags_q;
  logic [3:0]  cond_sel = 4'd0;
  logic        cond_true;
`ifdef ALU_WB_STICKY_V_EN
  logic        sticky_v;
  logic        sticky_clr = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_flags = 3'b000;
  logic       exp_sticky = 1'b0;

  alu_wb_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_z      (in_z),
    .in_c      (in_c),
    .in_v      (in_v),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .in_fwe    (in_fwe),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .flags_q   (flags_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
`ifdef ALU_WB_STICKY_V_EN
    ,
    .sticky_v  (sticky_v),
    .sticky_clr(sticky_clr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference condition table, straight from the cond_sel definition.
  function automatic logic cond_ref(input logic [2:0] f, input logic [3:0] sel);
    logic z;
    logic c;
    logic v;
    z = f[2];
    c = f[1];
    v = f[0];
    case (sel)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return c;
      4'd3: return !c;
      4'd4: return v;
      4'd5: return !v;
      4'd6: return c && !z;
      4'd7: return !c || z;
      4'd8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input ent_t e);
    in_valid = 1'b1;
    in_res   = e.res;
    in_rd    = e.rd;
    in_wen   = e.wen;
    in_fwe   = e.fwe;
    in_z     = e.flg[2];
    in_c     = e.flg[1];
    in_v     = e.flg[0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_res !== 32'd0) begin failures++; $display("FAIL reset_out_res got=%h exp=0", out_res); end
    checks++; if (out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%h exp=0", out_rd); end
    checks++; if (out_wen !== 1'b0) begin failures++; $display("FAIL reset_out_wen got=%0b exp=0", out_wen); end
    checks++; if (flags_q !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags_q); end
`ifdef ALU_WB_STICKY_V_EN
    checks++; if (sticky_v !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%0b exp=0", sticky_v); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_release got=%0b/%0b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    ent_t e;
    logic [31:0] got[$];
    logic sent;
    out_ready = 1'b0;
    e = '{res: 32'd1, rd: 5'd1, wen: 1'b1, fwe: 1'b0, flg: 3'b000};
    drive(e);
    @(negedge clk);
    e.res = 32'd2; e.rd = 5'd2;
    drive(e);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
    checks++; if (out_res !== 32'd1) begin failures++; $display("FAIL bp_head got=%h exp=1", out_res); end
    e.res = 32'd3; e.rd = 5'd3;
    drive(e);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%0b exp=0", in_ready); end
    checks++; if (out_res !== 32'd1 || out_rd !== 5'd1 || out_wen !== 1'b1) begin failures++; $display("FAIL bp_stall_stable got=%h/%h/%0b exp=1/1/1", out_res, out_rd, out_wen); end
    out_ready = 1'b1;
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      if (out_valid && out_ready) got.push_back(out_res);
      sent = in_valid && in_ready;
      @(negedge clk);
      if (sent) in_valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 32'(i + 1)) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], i + 1); end
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_drained got=%0b/%0b exp=0/1", out_valid, in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    ent_t e;
    logic [31:0] exp_q[$];
    out_ready = 1'b0;
    e = '{res: $urandom, rd: 5'($urandom), wen: 1'b1, fwe: 1'b0, flg: 3'b000};
    drive(e);
    exp_q.push_back(e.res);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0b/%0b exp=1/1", i, out_valid, in_ready); end
      checks++; if (out_res !== exp_q[0]) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, out_res, exp_q[0]); end
      void'(exp_q.pop_front());
      e.res = $urandom;
      e.rd  = 5'($urandom);
      drive(e);
      exp_q.push_back(e.res);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_res !== exp_q[0]) begin failures++; $display("FAIL b2b_last got=%h exp=%h", out_res, exp_q[0]); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flags();
    ent_t e;
    out_ready = 1'b0;
    e = '{res: 32'hA, rd: 5'd4, wen: 1'b0, fwe: 1'b1, flg: 3'b100};
    drive(e);
    @(negedge clk);
    e = '{res: 32'hB, rd: 5'd5, wen: 1'b1, fwe: 1'b0, flg: 3'b011};
    drive(e);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (flags_q !== 3'b000) begin failures++; $display("FAIL flag_accept_only got=%b exp=000", flags_q); end
    checks++; if (out_wen !== 1'b0) begin failures++; $display("FAIL flag_head_wen got=%0b exp=0", out_wen); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (flags_q !== 3'b100) begin failures++; $display("FAIL flag_commit got=%b exp=100", flags_q); end
    checks++; if (out_res !== 32'hB || out_wen !== 1'b1) begin failures++; $display("FAIL flag_second_head got=%h/%0b exp=b/1", out_res, out_wen); end
    @(negedge clk);
    checks++; if (flags_q !== 3'b100) begin failures++; $display("FAIL flag_fwe0_hold got=%b exp=100", flags_q); end
    checks++; if (out_valid !== 1'b0 || out_wen !== 1'b0) begin failures++; $display("FAIL flag_drain got=%0b/%0b exp=0/0", out_valid, out_wen); end
    out_ready = 1'b0;
    cond_sel = COND_EQ; #1;
    checks++; if (cond_true !== 1'b1) begin failures++; $display("FAIL flag_cond_eq got=%0b exp=1", cond_true); end
    cond_sel = COND_NE; #1;
    checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL flag_cond_ne got=%0b exp=0", cond_true); end
    cond_sel = COND_HI; #1;
    checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL flag_cond_hi got=%0b exp=0", cond_true); end
    @(negedge clk);
  endtask

  task automatic test_cond_sweep();
    ent_t e;
    logic [3:0] s4;
    e = '{res: 32'h10, rd: 5'd6, wen: 1'b1, fwe: 1'b1, flg: 3'b010};
    drive(e);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (flags_q !== 3'b010) begin failures++; $display("FAIL cond_setup got=%b exp=010", flags_q); end
    for (int s = 0; s < 16; s++) begin
      s4 = 4'(s);
      cond_sel = s4;
      #1;
      checks++; if (cond_true !== cond_ref(3'b010, s4)) begin failures++; $display("FAIL cond_sweep sel=%0d got=%0b exp=%0b", s, cond_true, cond_ref(3'b010, s4)); end
    end
    exp_flags = 3'b010;
    @(negedge clk);
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t cur;
    logic acc;
    logic com;
    cur = '{res: 32'd0, rd: 5'd0, wen: 1'b0, fwe: 1'b0, flg: 3'b000};
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      checks++; if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (out_res !== q[0].res) begin failures++; $display("FAIL rnd_res cyc=%0d got=%h exp=%h", i, out_res, q[0].res); end
        checks++; if (out_rd !== q[0].rd) begin failures++; $display("FAIL rnd_rd cyc=%0d got=%h exp=%h", i, out_rd, q[0].rd); end
        checks++; if (out_wen !== q[0].wen) begin failures++; $display("FAIL rnd_wen cyc=%0d got=%0b exp=%0b", i, out_wen, q[0].wen); end
      end else begin
        checks++; if (out_wen !== 1'b0) begin failures++; $display("FAIL rnd_wen_idle cyc=%0d got=%0b exp=0", i, out_wen); end
      end
      checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, in_ready, q.size() < 2); end
      checks++; if (flags_q !== exp_flags) begin failures++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, flags_q, exp_flags); end
      checks++; if (cond_true !== cond_ref(exp_flags, cond_sel)) begin failures++; $display("FAIL rnd_cond cyc=%0d sel=%0d got=%0b exp=%0b", i, cond_sel, cond_true, cond_ref(exp_flags, cond_sel)); end
`ifdef ALU_WB_STICKY_V_EN
      checks++; if (sticky_v !== exp_sticky) begin failures++; $display("FAIL rnd_sticky cyc=%0d got=%0b exp=%0b", i, sticky_v, exp_sticky); end
`endif
      if (!(in_valid && q.size() == 2)) begin
        cur.res = $urandom;
        cur.rd  = 5'($urandom);
        cur.wen = 1'($urandom);
        cur.fwe = 1'($urandom);
        cur.flg = 3'($urandom);
        drive(cur);
        in_valid = ($urandom_range(0, 2) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cond_sel = 4'($urandom);
      acc = in_valid && (q.size() < 2);
      com = out_ready && (q.size() != 0);
`ifdef ALU_WB_STICKY_V_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
      if (com && q[0].fwe && q[0].flg[0]) exp_sticky = 1'b1;
      else if (sticky_clr) exp_sticky = 1'b0;
`endif
      if (com) begin
        if (q[0].fwe) exp_flags = q[0].flg;
        void'(q.pop_front());
      end
      if (acc) q.push_back(cur);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef ALU_WB_STICKY_V_EN
    sticky_clr = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      if (q.size() != 0) begin
        if (q[0].fwe && q[0].flg[0]) exp_sticky = 1'b1;
        if (q[0].fwe) exp_flags = q[0].flg;
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%0b exp=0", out_valid); end
    checks++; if (flags_q !== exp_flags) begin failures++; $display("FAIL rnd_drain_flags got=%b exp=%b", flags_q, exp_flags); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    ent_t e;
    out_ready = 1'b1;
    e = '{res: 32'h55, rd: 5'd7, wen: 1'b1, fwe: 1'b1, flg: 3'b111};
    drive(e);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (flags_q !== 3'b111) begin failures++; $display("FAIL rmid_setup got=%b exp=111", flags_q); end
    out_ready = 1'b0;
    e = '{res: 32'h7, rd: 5'd8, wen: 1'b1, fwe: 1'b1, flg: 3'b101};
    drive(e);
    @(negedge clk);
    e.res = 32'h8;
    drive(e);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rmid_full got=%0b/%0b exp=1/0", out_valid, in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%0b exp=1", in_ready); end
    checks++; if (flags_q !== 3'b000) begin failures++; $display("FAIL rmid_flags got=%b exp=000", flags_q); end
    checks++; if (out_wen !== 1'b0) begin failures++; $display("FAIL rmid_wen got=%0b exp=0", out_wen); end
`ifdef ALU_WB_STICKY_V_EN
    checks++; if (sticky_v !== 1'b0) begin failures++; $display("FAIL rmid_sticky got=%0b exp=0", sticky_v); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_discard got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
    exp_flags = 3'b000;
    exp_sticky = 1'b0;
  endtask

`ifdef ALU_WB_STICKY_V_EN
  task automatic test_sticky();
    ent_t e;
    sticky_clr = 1'b0;
    out_ready = 1'b1;
    e = '{res: 32'h1, rd: 5'd1, wen: 1'b0, fwe: 1'b1, flg: 3'b001};
    drive(e);
    @(negedge clk);
    e.flg = 3'b000;
    drive(e);
    @(negedge clk);
    checks++; if (sticky_v !== 1'b1) begin failures++; $display("FAIL sticky_set got=%0b exp=1", sticky_v); end
    e.flg = 3'b001;
    drive(e);
    @(negedge clk);
    checks++; if (sticky_v !== 1'b1) begin failures++; $display("FAIL sticky_hold got=%0b exp=1", sticky_v); end
    in_valid = 1'b0;
    sticky_clr = 1'b1;
    @(negedge clk);
    checks++; if (sticky_v !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%0b exp=1", sticky_v); end
    @(negedge clk);
    checks++; if (sticky_v !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%0b exp=0", sticky_v); end
    sticky_clr = 1'b0;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_backpressure();
    test_back_to_back();
    test_flags();
    test_cond_sweep();
    test_random();
    test_reset_mid();
`ifdef ALU_WB_STICKY_V_EN
    test_sticky();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback/commit stage directly downstream of the 32-bit ALU (sel[2:0], flags z/c/v).
- Captures the ALU result, flags and destination tag through a valid/ready skid buffer.
- Commits flags into an architectural status register and evaluates branch condition codes against the committed flags.
- Feeds the register-file write port and the branch unit.

Parameters:
- DATA_W, 32, result width; must match the ALU result width.
- RD_W, 5, destination register tag width.
- DEPTH, 2, skid buffer entries; only the value 2 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept an entry; registered.
- in_res  in  DATA_W  ALU result.
- in_z, in_c, in_v  in  1 each  ALU flags.
- in_rd  in  RD_W  destination tag.
- in_wen  in  1  entry writes the register file.
- in_fwe  in  1  entry updates the status flags.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_res  out  DATA_W  head result.
- out_rd  out  RD_W  head tag.
- out_wen  out  1  head register-file write enable; qualified by out_valid.
- flags_q  out  3  committed flags {z,c,v}.
- cond_sel  in  4  condition code select.
- cond_true  out  1  condition evaluated on flags_q; combinational.

Behaviour:
- Reset (async assert, sync deassert usage) sets:
  - both buffer entries invalid;
  - out_valid=0, in_ready=1, out_res=0, out_rd=0, out_wen=0;
  - flags_q=3'b000.
- Accept: in_valid && in_ready at a rising edge.
- Commit: out_valid && out_ready at a rising edge.
- Latency: an entry accepted at edge N is visible on out_* after edge N; out_valid=1 during cycle N+1.
- Buffer: 2-entry FIFO (head + skid). Occupancy count 0..2.
  - in_ready = (count < 2), registered from next-state count.
  - Accept with count=2 cannot occur.
  - Simultaneous accept and commit: count unchanged; the skid entry (or the new entry if count=1) moves to the head; order preserved.
  - Commit with count=0 cannot occur, since out_valid=0.
- out_* are driven from the head register. When out_valid=0, out_res and out_rd hold their last values and out_wen is forced to 0.
- Handshake rules:
  - While out_valid=1 && out_ready=0, out_res/out_rd/out_wen stay stable.
  - Upstream must hold its inputs while in_valid && !in_ready; the stage does not check this.
- Flag commit: on commit of an entry with fwe=1, flags_q <= {z,c,v} of that entry. Entries with fwe=0 leave flags_q unchanged. Accept alone never changes flags_q.
- Condition codes (cond_sel):
  - 0 EQ z
  - 1 NE !z
  - 2 CS c
  - 3 CC !c
  - 4 VS v
  - 5 VC !v
  - 6 HI c&&!z
  - 7 LS !c||z
  - 8 AL 1
  - 9..15 NV 0
- Reset asserted mid-transfer discards all buffered entries immediately; no partial commit.

Optional Feature:
- Macro ALU_WB_STICKY_V_EN.
- Defined:
  - adds output sticky_v (1) and input sticky_clr (1);
  - sticky_v sets on any commit with fwe=1 and v=1, and clears on sticky_clr;
  - if set and clear occur in the same cycle, set wins;
  - reset value is 0.
- Undefined: neither port exists and no sticky logic is built.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and RD_W defaults;
  - the flag bit index constants FLG_Z=2, FLG_C=1, FLG_V=0;
  - the cond_sel encodings COND_EQ .. COND_NV as 4-bit localparams.
- One natural sub-module, alu_cond_eval: purely combinational mapping of (flags, cond_sel) to cond_true. It is reusable by the branch unit.

Test Plan:
- Reset mid-stream: push 2 entries, assert rst_n=0 -> out_valid=0, in_ready=1, flags_q=000 in the same cycle.
- Backpressure: out_ready=0; push res=32'h1, 32'h2, then a 3rd -> in_ready=0 after the 2nd accept. Release out_ready -> order 1, 2, then the 3rd accepted; no loss or duplication.
- Simultaneous accept and commit at count=1 over 100 cycles with random res -> out sequence equals the in sequence; count stays 1.
- Flag commit: entry fwe=1 {z,c,v}=100 committed, then entry fwe=0 {011} committed -> flags_q=100 after both; cond EQ=1, NE=0, HI=0.
- Condition sweep: flags_q=010 -> CS=1, HI=1, LS=0, VC=1, AL=1, cond_sel=12 gives 0.
- With ALU_WB_STICKY_V_EN: commit v=1 then v=0 -> sticky_v stays 1. sticky_clr coincident with a v=1 commit -> sticky_v=1. A lone sticky_clr -> 0.
